voice_phase_acc: RTL and testbench

VOICE_PHASE_ACC -- requirements
Module: voice_phase_acc

---
 rtl/voice_phase_acc.sv | 173 +++++++++++++++++
 tb/tb_voice_phase_acc.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/voice_phase_acc.sv
// voice_phase_acc: time-multiplexed phase accumulator for NBANKS voices, driven by note-on/off commands.
// Latency: outputs are registered and show the bank scanned on the previous clk_en cycle (1 cycle).
// Backpressure: none. A command is taken on any clk_en cycle. A note-on with no free bank is dropped and flagged on o_drop.
//
// Ports:
//   clk, rst (async active-low), clk_en (advance enable)
//   i_cmd_valid / i_cmd_on / i_midi / i_incr : note command (on = 1, off = 0)
//   o_phase / o_midi / o_valid / o_bank      : state of the bank scanned last cycle
//   o_full  : all banks active after last cycle's command
//   o_drop  : one-cycle pulse, previous note-on was rejected
module voice_phase_acc #(
  parameter int NBANKS  = 10,
  parameter int PHASE_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clk_en,
  input  logic               i_cmd_valid,
  input  logic               i_cmd_on,
  input  logic [6:0]         i_midi,
  input  logic [PHASE_W-1:0] i_incr,
  output logic [PHASE_W-1:0] o_phase,
  output logic [6:0]         o_midi,
  output logic               o_valid,
  output logic [3:0]         o_bank,
  output logic               o_full,
  output logic               o_drop
);

  // o_bank is 4 bits wide, so the scan index is 4 bits and NBANKS is limited to 16.
  localparam int              IDX_W    = 4;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBANKS - 1);

  // Per-bank voice state
  logic [PHASE_W-1:0] phase_q [NBANKS];
  logic [PHASE_W-1:0] incr_q  [NBANKS];
  logic [6:0]         midi_q  [NBANKS];
  logic [NBANKS-1:0]  active_q;

  logic [PHASE_W-1:0] phase_d [NBANKS];
  logic [PHASE_W-1:0] incr_d  [NBANKS];
  logic [6:0]         midi_d  [NBANKS];
  logic [NBANKS-1:0]  active_d;

  logic [IDX_W-1:0]   idx_q;
  logic [IDX_W-1:0]   idx_d;

  // Command decode
  logic               cmd_acc;
  logic               match_hit;
  logic [IDX_W-1:0]   match_idx;
  logic               free_hit;
  logic [IDX_W-1:0]   free_idx;
  logic               do_retrig;
  logic               do_alloc;
  logic               do_off;
  logic               drop_d;

  // Currently scanned bank, muxed out for the output registers
  logic [PHASE_W-1:0] sel_phase;
  logic [6:0]         sel_midi;
  logic               sel_valid;

  assign cmd_acc = i_cmd_valid & clk_en;

  // Match is searched among active banks only. Allocation always takes
  // the lowest-index free bank, which keeps voice placement deterministic.
  always_comb begin
    match_hit = 1'b0;
    match_idx = '0;
    free_hit  = 1'b0;
    free_idx  = '0;
    for (int b = 0; b < NBANKS; b++) begin
      if (!match_hit && active_q[b] && (midi_q[b] == i_midi)) begin
        match_hit = 1'b1;
        match_idx = IDX_W'(b);
      end
      if (!free_hit && !active_q[b]) begin
        free_hit = 1'b1;
        free_idx = IDX_W'(b);
      end
    end
  end

  assign do_retrig = cmd_acc &  i_cmd_on & match_hit;
  assign do_alloc  = cmd_acc &  i_cmd_on & ~match_hit & free_hit;
  assign do_off    = cmd_acc & ~i_cmd_on & match_hit;
  assign drop_d    = cmd_acc &  i_cmd_on & ~match_hit & ~free_hit;

  assign idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;

  always_comb begin
    sel_phase = '0;
    sel_midi  = '0;
    sel_valid = 1'b0;
    for (int b = 0; b < NBANKS; b++) begin
      if (idx_q == IDX_W'(b)) begin
        sel_phase = phase_q[b];
        sel_midi  = midi_q[b];
        sel_valid = active_q[b];
      end
    end
  end

  // Next-state per bank. The accumulate of the scanned bank is written
  // first so that a command hitting the same bank overrides it.
  always_comb begin
    active_d = active_q;
    for (int b = 0; b < NBANKS; b++) begin
      phase_d[b] = phase_q[b];
      incr_d[b]  = incr_q[b];
      midi_d[b]  = midi_q[b];

      if (clk_en && (idx_q == IDX_W'(b)) && active_q[b]) begin
        phase_d[b] = phase_q[b] + incr_q[b];
      end

      if (do_retrig && (match_idx == IDX_W'(b))) begin
        phase_d[b] = '0;
        incr_d[b]  = i_incr;
      end

      if (do_alloc && (free_idx == IDX_W'(b))) begin
        active_d[b] = 1'b1;
        midi_d[b]   = i_midi;
        incr_d[b]   = i_incr;
        phase_d[b]  = '0;
      end

      if (do_off && (match_idx == IDX_W'(b))) begin
        active_d[b] = 1'b0;
        phase_d[b]  = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int b = 0; b < NBANKS; b++) begin
        phase_q[b] <= '0;
        incr_q[b]  <= '0;
        midi_q[b]  <= '0;
      end
      active_q <= '0;
      idx_q    <= '0;
      o_phase  <= '0;
      o_midi   <= '0;
      o_valid  <= 1'b0;
      o_bank   <= '0;
      o_full   <= 1'b0;
      o_drop   <= 1'b0;
    end else begin
      // The drop flag is a strict one-cycle pulse, so it clears even while stalled.
      o_drop <= drop_d;
      if (clk_en) begin
        for (int b = 0; b < NBANKS; b++) begin
          phase_q[b] <= phase_d[b];
          incr_q[b]  <= incr_d[b];
          midi_q[b]  <= midi_d[b];
        end
        active_q <= active_d;
        idx_q    <= idx_d;
        // Outputs carry the pre-update state of the scanned bank.
        o_phase  <= sel_phase;
        o_midi   <= sel_midi;
        o_valid  <= sel_valid;
        o_bank   <= idx_q;
        o_full   <= &active_d;
      end
    end
  end

endmodule

// File: tb/tb_voice_phase_acc.sv
// tb_voice_phase_acc: directed-vector bench for voice_phase_acc.
// Latency: one edge per tick; outputs are sampled 1 time unit after each rising edge.
// Backpressure: none on the DUT; the bench drives commands on chosen edges.
module tb_voice_phase_acc;

  logic        clk;
  logic        rst;
  logic        clk_en;
  logic        i_cmd_valid;
  logic        i_cmd_on;
  logic [6:0]  i_midi;
  logic [15:0] i_incr;
  logic [15:0] o_phase;
  logic [6:0]  o_midi;
  logic        o_valid;
  logic [3:0]  o_bank;
  logic        o_full;
  logic        o_drop;

  int n_checks;
  int n_pass;

  voice_phase_acc #(.NBANKS(10), .PHASE_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .clk_en      (clk_en),
    .i_cmd_valid (i_cmd_valid),
    .i_cmd_on    (i_cmd_on),
    .i_midi      (i_midi),
    .i_incr      (i_incr),
    .o_phase     (o_phase),
    .o_midi      (o_midi),
    .o_valid     (o_valid),
    .o_bank      (o_bank),
    .o_full      (o_full),
    .o_drop      (o_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic cmd_tick(input logic on, input logic [6:0] m, input logic [15:0] inc);
    i_cmd_valid = 1'b1;
    i_cmd_on    = on;
    i_midi      = m;
    i_incr      = inc;
    tick();
    i_cmd_valid = 1'b0;
    i_cmd_on    = 1'b0;
    i_midi      = '0;
    i_incr      = '0;
  endtask

  // Called 1 unit after an edge; the pulse ends well before the next edge.
  task automatic do_reset();
    rst = 1'b0;
    #2;
    rst = 1'b1;
    #1;
  endtask

  task automatic check_out(input string tag, input logic [15:0] ph, input logic [6:0] m,
                           input logic v, input logic [3:0] bk);
    check({tag, "_phase"}, o_phase, ph);
    check({tag, "_midi"},  o_midi,  m);
    check({tag, "_valid"}, o_valid, v);
    check({tag, "_bank"},  o_bank,  bk);
  endtask

  logic [15:0] wrap_seq [5];

  initial begin
    n_checks    = 0;
    n_pass      = 0;
    rst         = 1'b0;
    clk_en      = 1'b0;
    i_cmd_valid = 1'b0;
    i_cmd_on    = 1'b0;
    i_midi      = '0;
    i_incr      = '0;
    wrap_seq[0] = 16'h0000;
    wrap_seq[1] = 16'hC000;
    wrap_seq[2] = 16'h8000;
    wrap_seq[3] = 16'h4000;
    wrap_seq[4] = 16'h0000;

    // Reset state, before any clock edge
    #3;
    check_out("rst", 16'h0, 7'd0, 1'b0, 4'd0);
    check("rst_full", o_full, 1'b0);
    check("rst_drop", o_drop, 1'b0);
    rst    = 1'b1;
    clk_en = 1'b1;

    // Idle scan: banks 0..9,0,1 with nothing active
    for (int e = 1; e <= 12; e++) begin
      tick();
      check("idle_bank",  o_bank,  (e - 1) % 10);
      check("idle_valid", o_valid, 1'b0);
      check("idle_phase", o_phase, 16'h0);
    end

    // Note-on 60 incr 0x1000 lands in bank 0; phase steps by 0x1000 per scan
    do_reset();
    cmd_tick(1'b1, 7'd60, 16'h1000);                 // edge 1
    check("alloc_prewrite_valid", o_valid, 1'b0);
    check("alloc_full", o_full, 1'b0);
    check("alloc_drop", o_drop, 1'b0);
    ticks(10);                                       // edge 11
    check_out("alloc_e11", 16'h0000, 7'd60, 1'b1, 4'd0);
    ticks(10);                                       // edge 21
    check_out("alloc_e21", 16'h1000, 7'd60, 1'b1, 4'd0);
    ticks(10);                                       // edge 31
    check_out("alloc_e31", 16'h2000, 7'd60, 1'b1, 4'd0);

    // Increment 0xC000 wraps modulo 2^16
    do_reset();
    cmd_tick(1'b1, 7'd60, 16'hC000);                 // edge 1
    for (int s = 0; s < 5; s++) begin
      ticks(10);                                     // edges 11,21,31,41,51
      check("wrap_phase", o_phase, wrap_seq[s]);
      check("wrap_bank",  o_bank,  4'd0);
    end

    // Fill all ten banks, overflow, free one, reallocate
    do_reset();
    for (int k = 0; k < 10; k++) begin
      cmd_tick(1'b1, 7'(60 + k), 16'h0100);          // edges 1..10
      check("fill_full", o_full, (k == 9) ? 1'b1 : 1'b0);
    end
    check("fill_drop_none", o_drop, 1'b0);
    cmd_tick(1'b1, 7'd70, 16'h0100);                 // edge 11: rejected
    check("ovf_drop", o_drop, 1'b1);
    check("ovf_full", o_full, 1'b1);
    check_out("ovf_e11", 16'h0000, 7'd60, 1'b1, 4'd0);
    tick();                                          // edge 12
    check("ovf_drop_clear", o_drop, 1'b0);
    check("ovf_e12_midi", o_midi, 7'd61);
    for (int e = 13; e <= 22; e++) begin
      tick();
      check("ovf_scan_bank",  o_bank,  (e - 1) % 10);
      check("ovf_scan_midi",  o_midi,  60 + (e - 1) % 10);
      check("ovf_scan_valid", o_valid, 1'b1);
    end
    cmd_tick(1'b0, 7'd63, 16'h0);                    // edge 23: note-off 63
    check("off_full", o_full, 1'b0);
    tick();                                          // edge 24: bank 3
    check("off_bank",  o_bank,  4'd3);
    check("off_valid", o_valid, 1'b0);
    check("off_phase", o_phase, 16'h0);
    cmd_tick(1'b1, 7'd70, 16'h0200);                 // edge 25: takes bank 3
    check("realloc_full", o_full, 1'b1);
    check("realloc_drop", o_drop, 1'b0);
    ticks(9);                                        // edge 34: bank 3
    check_out("realloc_e34", 16'h0000, 7'd70, 1'b1, 4'd3);

    // Retrigger and unmatched note-off
    do_reset();
    cmd_tick(1'b1, 7'd60, 16'h1000);                 // edge 1
    ticks(20);                                       // edge 21
    check("retrig_pre_phase", o_phase, 16'h1000);
    cmd_tick(1'b1, 7'd60, 16'h0400);                 // edge 22: retrigger bank 0
    check("retrig_e22_bank",  o_bank,  4'd1);
    check("retrig_e22_valid", o_valid, 1'b0);
    ticks(9);                                        // edge 31
    check_out("retrig_e31", 16'h0000, 7'd60, 1'b1, 4'd0);
    tick();                                          // edge 32: bank 1 not allocated
    check("retrig_no_alloc_bank",  o_bank,  4'd1);
    check("retrig_no_alloc_valid", o_valid, 1'b0);
    ticks(2);                                        // edge 34
    cmd_tick(1'b0, 7'd99, 16'h0);                    // edge 35: no match
    check("off99_drop", o_drop, 1'b0);
    check("off99_full", o_full, 1'b0);
    ticks(6);                                        // edge 41
    check_out("retrig_e41", 16'h0400, 7'd60, 1'b1, 4'd0);
    ticks(10);                                       // edge 51
    check_out("retrig_e51", 16'h0800, 7'd60, 1'b1, 4'd0);

    // Stall with clk_en=0, ignored command, then async reset mid-scan
    do_reset();
    cmd_tick(1'b1, 7'd60, 16'h1000);                 // edge 1
    ticks(20);                                       // edge 21
    check_out("stall_pre", 16'h1000, 7'd60, 1'b1, 4'd0);
    clk_en      = 1'b0;
    i_cmd_valid = 1'b1;
    i_cmd_on    = 1'b1;
    i_midi      = 7'd61;
    i_incr      = 16'h0300;
    for (int k = 0; k < 5; k++) begin
      tick();
      check_out("stall_hold", 16'h1000, 7'd60, 1'b1, 4'd0);
      check("stall_drop", o_drop, 1'b0);
    end
    i_cmd_valid = 1'b0;
    i_cmd_on    = 1'b0;
    i_midi      = '0;
    i_incr      = '0;
    clk_en      = 1'b1;
    tick();                                          // enabled edge 22: bank 1
    check("stall_resume_bank",  o_bank,  4'd1);
    check("stall_ignored_cmd",  o_valid, 1'b0);
    ticks(9);                                        // enabled edge 31
    check_out("stall_e31", 16'h2000, 7'd60, 1'b1, 4'd0);
    tick();                                          // edge 32: bank 1
    check("pre_areset_bank", o_bank, 4'd1);
    rst = 1'b0;
    #2;                                              // no clock edge in between
    check_out("areset", 16'h0, 7'd0, 1'b0, 4'd0);
    check("areset_full", o_full, 1'b0);
    rst = 1'b1;
    #1;
    tick();                                          // first edge after release
    check_out("post_rst_e1", 16'h0, 7'd0, 1'b0, 4'd0);
    ticks(10);                                       // edge 11: voice was discarded
    check_out("post_rst_e11", 16'h0, 7'd0, 1'b0, 4'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
